i2c_target_rx: RTL and testbench
================================

// Module: i2c_target_rx
// PURPOSE
//   I2C target (slave) receiver: the far end of the I2C write master. Oversamples SCL/SDA on the
//   system clock and detects START/STOP. Matches a 7-bit address, ACKs by driving SDA low, and
//   shifts in written bytes MSB-first. Received bytes go into a 2-entry double buffer that
//   drains over a valid/ready interface. Write-only: read requests are NACKed.
// PARAMETERS
//   OWN_ADDR  7'h50  7-bit target address this block responds to
// PORTS
//   clk          in   1  system clock, >= 8x SCL rate; all logic on rising edge
//   rst          in   1  synchronous, active-high reset
//   scl_in       in   1  raw SCL from pad (asynchronous)
//   sda_in       in   1  raw SDA from pad (asynchronous)
//   sda_oe       out  1  1 = pull SDA low (open-drain); 0 = release (pad drives 1'bz)
//   rx_data      out  8  head-of-buffer byte
//   rx_valid     out  1  rx_data holds an unread byte
//   rx_ready     in   1  consumer accepts rx_data when rx_valid && rx_ready
//   busy         out  1  1 from address-match ACK until STOP or repeated START
//   overflow     out  1  sticky; set when a data byte is NACKed because the buffer is full
// BEHAVIOUR
//   - Reset: sda_oe=0, rx_valid=0, rx_data=8'h00, busy=0, overflow=0, buffer empty, state IDLE.
//     Reset mid-transfer releases SDA in the same cycle; the partial byte is discarded.
//   - Sync: each of scl_in/sda_in passes through a 2-FF synchronizer plus 1 history flop.
//     scl_rise/scl_fall/sda_rise/sda_fall are single-cycle pulses on the synchronized signals.
//   - START = sda_fall while scl_s=1; STOP = sda_rise while scl_s=1. Both are valid in every
//     state, including repeated START. START -> ADDR with bit count cleared, sda_oe=0.
//     STOP -> IDLE, sda_oe=0, busy=0.
//   - Data bits are sampled on scl_rise into an 8-bit shift register, MSB first; count 0..7.
//   - States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
//     IDLE: wait for START.
//     ADDR: after 8th scl_rise, test the byte. If [7:1]==OWN_ADDR && [0]==0, set ack_pend and
//       busy=1. Otherwise (address mismatch or read request) go to IGNORE; SDA is never driven.
//     ACK drive: on the scl_fall ending bit 8, sda_oe=1 and enter ADDR_ACK/DATA_ACK. On the next
//       scl_fall (end of ACK clock), sda_oe=0 and enter DATA with count=0.
//     DATA: after 8th scl_rise, if the buffer has a free slot, write the byte into it in the next
//       cycle and ACK as above. If the buffer is full, set overflow, NACK (sda_oe stays 0), and
//       go to IGNORE.
//     IGNORE: SDA stays released; only START or STOP leave this state.
//   - sda_oe changes only in the cycle after a synchronized scl_fall, or on STOP/START/reset.
//     It never changes while scl_s=1.
//   - Buffer: 2 entries, write and read pointers, count 0..2.
//     rx_valid = (count!=0); rx_data = entry[rd_ptr].
//     Pop on rx_valid && rx_ready. A simultaneous push and pop leaves count unchanged.
//     A push when count==2 cannot occur, because the byte was already NACKed.
//   - Latency: rx_valid rises 1 clk after the cycle in which the 8th synchronized scl_rise is
//     detected (about 4 clk after the raw pad edge).
//   - overflow clears only on rst.
// TESTING
//   1. Write 0xA0 (addr 0x50, W) then 0x3C, STOP -> ACK on both bytes; rx_data=0x3C with rx_valid;
//      busy=1 until STOP, then 0.
//   2. Address 0x51 with W -> no ACK, sda_oe=0 throughout; subsequent bytes produce no rx_valid.
//   3. Address 0x50 with R (0xA1) -> NACK; state IGNORE; busy stays 0.
//   4. rx_ready=0, write 0x11, 0x22, 0x33 -> first two ACKed, third NACKed; overflow=1;
//      raise rx_ready -> pops 0x11 then 0x22.
//   5. Repeated START after 4 data bits, then 0xA0 and 0x55 -> partial byte dropped;
//      0x55 delivered.
//   6. Assert rst while sda_oe=1 during ACK -> sda_oe=0 the next cycle; all outputs at reset
//      values; the next START is handled normally.

Source files
------------

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target. Oversamples SCL/SDA, detects START/STOP,
// matches OWN_ADDR, ACKs by pulling SDA low and delivers received bytes through a
// 2-entry buffer.
//
// Handshake: a byte transfers on rx_data in every cycle where rx_valid && rx_ready
// are both high. rx_valid stays high and rx_data stays stable until that transfer.
// rx_valid does not depend on rx_ready.
module i2c_target_rx #(
    parameter logic [6:0] OWN_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overflow,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        scl_m_q, scl_m_d, scl_s_q, scl_s_d, scl_h_q, scl_h_d;
    logic        sda_m_q, sda_m_d, sda_s_q, sda_s_d, sda_h_q, sda_h_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ack_pend_q, ack_pend_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  mem_q [0:1];
    logic [7:0]  mem_d [0:1];
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
    logic push, pop;
    logic [7:0] byte_in;

    assign scl_rise  = scl_s_q & ~scl_h_q;
    assign scl_fall  = ~scl_s_q & scl_h_q;
    assign sda_rise  = sda_s_q & ~sda_h_q;
    assign sda_fall  = ~sda_s_q & sda_h_q;
    assign start_det = sda_fall & scl_s_q;
    assign stop_det  = sda_rise & scl_s_q;
    // Byte as it will look once the current bit is shifted in.
    assign byte_in   = {shreg_q[6:0], sda_s_q};

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign rx_valid  = (count_q != 2'd0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign state_dbg = state_q;

    // Next-state logic: synchronizers, bus protocol FSM and receive buffer.
    always_comb begin
        scl_m_d    = scl_in;
        scl_s_d    = scl_m_q;
        scl_h_d    = scl_s_q;
        sda_m_d    = sda_in;
        sda_s_d    = sda_m_q;
        sda_h_d    = sda_s_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ack_pend_d = ack_pend_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = rx_valid & rx_ready;

        if (start_det) begin
            state_d    = ADDR;
            cnt_d      = 3'd0;
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_det) begin
            state_d    = IDLE;
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (ack_pend_q) begin
                        // Byte accepted: pull SDA low once SCL is safely low.
                        if (scl_fall) begin
                            ack_pend_d = 1'b0;
                            sda_oe_d   = 1'b1;
                            state_d    = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                        end
                    end else if (scl_rise) begin
                        shreg_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (byte_in[7:1] == OWN_ADDR && !byte_in[0]) begin
                                    ack_pend_d = 1'b1;
                                    busy_d     = 1'b1;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (count_q != 2'd2) begin
                                push       = 1'b1;
                                ack_pend_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                                state_d    = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // End of the ACK clock: release SDA, next data byte follows.
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = DATA;
                    end
                end
                default: ;
            endcase
        end

        if (push) begin
            mem_d[wr_ptr_q] = byte_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m_q    <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_m_q    <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shreg_q    <= 8'h00;
            ack_pend_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            mem_q[0]   <= 8'h00;
            mem_q[1]   <= 8'h00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            scl_m_q    <= scl_m_d;
            scl_s_q    <= scl_s_d;
            scl_h_q    <= scl_h_d;
            sda_m_q    <= sda_m_d;
            sda_s_q    <= sda_s_d;
            sda_h_q    <= sda_h_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ack_pend_q <= ack_pend_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed testbench for i2c_target_rx: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_target_rx;

    localparam int Q = 6;  // clocks per quarter SCL period

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_IGNORE = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy;
    logic       overflow;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_oe  = 0;
    logic oe_seen = 1'b0;
    logic oe_prev = 1'b0;
    logic [3:0] scl_hist = 4'h0;
    logic ack;

    // Open-drain bus: target pulls low when sda_oe is set.
    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.OWN_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overflow (overflow),
        .state_dbg(state_dbg)
    );

    // Watch for sda_oe moving while SCL has been high for a while.
    always @(negedge clk) begin
        if (!rst && sda_oe !== oe_prev && scl_hist == 4'hF && m_scl) bad_oe++;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        oe_prev  = sda_oe;
        scl_hist = {scl_hist[2:0], m_scl};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START or repeated START; leaves SCL low.
    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clks(Q);
        m_scl = 1'b1; wait_clks(2 * Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    // Eight data bits then the ACK clock; ack_o = 1 when the target pulled SDA low.
    task automatic send_byte(input logic [7:0] b, output logic ack_o);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_clks(Q);
        ack_o = ~sda_bus;
        wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic pop_one(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rx_valid, 1'b1);
        check({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        check("rst_oe", sda_oe, 1'b0);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_state", state_dbg, S_IDLE);

        // 1: simple write of one byte
        i2c_start();
        check("t1_state_start", state_dbg, S_ADDR);
        send_byte(8'hA0, ack);
        check("t1_addr_ack", ack, 1'b1);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h3C, ack);
        check("t1_data_ack", ack, 1'b1);
        check("t1_oe_released", sda_oe, 1'b0);
        i2c_stop();
        check("t1_busy_stop", busy, 1'b0);
        check("t1_state_stop", state_dbg, S_IDLE);
        pop_one("t1_pop", 8'h3C);
        check("t1_empty", rx_valid, 1'b0);

        // 2: wrong address
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'hA2, ack);
        check("t2_addr_nack", ack, 1'b0);
        check("t2_state", state_dbg, S_IGNORE);
        send_byte(8'h77, ack);
        check("t2_data_nack", ack, 1'b0);
        check("t2_valid", rx_valid, 1'b0);
        check("t2_oe_seen", oe_seen, 1'b0);
        i2c_stop();

        // 3: read request to own address
        i2c_start();
        send_byte(8'hA1, ack);
        check("t3_nack", ack, 1'b0);
        check("t3_state", state_dbg, S_IGNORE);
        check("t3_busy", busy, 1'b0);
        i2c_stop();

        // 4: buffer full with consumer stalled
        i2c_start();
        send_byte(8'hA0, ack);
        check("t4_addr_ack", ack, 1'b1);
        send_byte(8'h11, ack);
        check("t4_ack1", ack, 1'b1);
        send_byte(8'h22, ack);
        check("t4_ack2", ack, 1'b1);
        check("t4_ovf_before", overflow, 1'b0);
        send_byte(8'h33, ack);
        check("t4_nack3", ack, 1'b0);
        check("t4_ovf", overflow, 1'b1);
        check("t4_state", state_dbg, S_IGNORE);
        i2c_stop();
        pop_one("t4_pop1", 8'h11);
        pop_one("t4_pop2", 8'h22);
        check("t4_empty", rx_valid, 1'b0);
        check("t4_ovf_sticky", overflow, 1'b1);

        // 5: repeated START drops a partial byte
        i2c_start();
        send_byte(8'hA0, ack);
        check("t5_addr_ack", ack, 1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_start();
        check("t5_rs_state", state_dbg, S_ADDR);
        check("t5_rs_busy", busy, 1'b0);
        check("t5_rs_valid", rx_valid, 1'b0);
        send_byte(8'hA0, ack);
        check("t5_addr2_ack", ack, 1'b1);
        send_byte(8'h55, ack);
        check("t5_data_ack", ack, 1'b1);
        i2c_stop();
        pop_one("t5_pop", 8'h55);
        check("t5_empty", rx_valid, 1'b0);

        // 6: reset while the target is driving ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        check("t6_oe_ack", sda_oe, 1'b1);
        check("t6_busy", busy, 1'b1);
        rst = 1'b1;
        wait_clks(1);
        check("t6_rst_oe", sda_oe, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ovf", overflow, 1'b0);
        check("t6_rst_valid", rx_valid, 1'b0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_state", state_dbg, S_IDLE);
        rst = 1'b0;
        wait_clks(2);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, ack);
        check("t6_addr_ack", ack, 1'b1);
        send_byte(8'h9A, ack);
        check("t6_data_ack", ack, 1'b1);
        i2c_stop();
        pop_one("t6_pop", 8'h9A);

        check("oe_stable_scl_high", bad_oe, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
